// File: rtl/pc_seq_pkg.sv
// Shared branch-condition encodings and the condition evaluator for pc_sequencer.
package pc_seq_pkg;

    localparam int unsigned COND_W = 2;

    localparam logic [COND_W-1:0] COND_BEQ = 2'd0;
    localparam logic [COND_W-1:0] COND_BNE = 2'd1;
    localparam logic [COND_W-1:0] COND_BLT = 2'd2;
    localparam logic [COND_W-1:0] COND_BGE = 2'd3;

    // Resolve a conditional branch from the ALU flags.
    function automatic logic cond_taken(input logic [COND_W-1:0] cond,
                                        input logic zero,
                                        input logic neg);
        logic taken;
        unique case (cond)
            COND_BEQ: taken = zero;
            COND_BNE: taken = ~zero;
            COND_BLT: taken = neg;
            default:  taken = ~neg;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: a push onto a full stack overwrites the oldest entry.
module ras_stack #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));
    assign top   = mem[wr_ptr - PTR_W'(1)];

    // wr_ptr points at the next free slot, which is the oldest entry once full.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= push & full;
            underflow <= pop & empty;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                if (!full) begin
                    count <= count + CNT_W'(1);
                end
            end else if (pop && !empty) begin
                wr_ptr <= wr_ptr - PTR_W'(1);
                count  <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter register with prioritised next-PC selection, branches, jumps and call/return.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned          PC_WIDTH   = 16,
    parameter int unsigned          INST_BYTES = 2,
    parameter int unsigned          RAS_DEPTH  = 4,
    parameter logic [PC_WIDTH-1:0]  RESET_PC   = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                br_valid,
    input  logic [COND_W-1:0]   br_cond,
    input  logic                zero,
    input  logic                neg,
    input  logic [PC_WIDTH-1:0] offset,
    input  logic                jump,
    input  logic                call,
    input  logic                ret,
    input  logic [PC_WIDTH-1:0] jump_target,
    output logic [PC_WIDTH-1:0] pc,
    output logic                redirected,
    output logic                ras_overflow,
    output logic                ras_underflow
);

    localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(INST_BYTES);

    logic [PC_WIDTH-1:0] next_pc;
    logic [PC_WIDTH-1:0] seq_pc;
    logic [PC_WIDTH-1:0] ras_top;
    logic                redirect_next;
    logic                push;
    logic                pop;
    logic                ras_empty;
    logic                ras_full;

    assign seq_pc = pc + STEP;

    // Next-PC priority: stall, ret, call, jump, taken branch, sequential.
    always_comb begin
        next_pc       = seq_pc;
        redirect_next = 1'b0;
        push          = 1'b0;
        pop           = 1'b0;
        if (stall) begin
            next_pc = pc;
        end else if (ret) begin
            pop           = 1'b1;
            redirect_next = 1'b1;
            if (!ras_empty) begin
                next_pc = ras_top;
            end
        end else if (call) begin
            push          = 1'b1;
            redirect_next = 1'b1;
            next_pc       = jump_target;
        end else if (jump) begin
            redirect_next = 1'b1;
            next_pc       = jump_target;
        end else if (br_valid && cond_taken(br_cond, zero, neg)) begin
            redirect_next = 1'b1;
            next_pc       = pc + offset;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc         <= RESET_PC;
            redirected <= 1'b0;
        end else begin
            pc         <= next_pc;
            redirected <= redirect_next;
        end
    end

    ras_stack #(
        .WIDTH (PC_WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (push && !reset),
        .pop       (pop && !reset),
        .push_data (seq_pc),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full),
        .overflow  (ras_overflow),
        .underflow (ras_underflow)
    );

    // A push reports overflow on the following edge exactly when the stack was full.
    a_overflow_tracks_full: assert property (
        @(posedge clk) disable iff (reset) (push && !stall) |=> (ras_overflow == $past(ras_full))
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, hand sequences, random vs reference model.
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        br_valid;
    logic [1:0]  br_cond;
    logic        zero;
    logic        neg;
    logic [15:0] offset;
    logic        jump;
    logic        call;
    logic        ret;
    logic [15:0] jump_target;
    logic [15:0] pc;
    logic        redirected;
    logic        ras_overflow;
    logic        ras_underflow;

    int checks = 0;
    int errors = 0;

    pc_sequencer #(
        .PC_WIDTH   (16),
        .INST_BYTES (2),
        .RAS_DEPTH  (4),
        .RESET_PC   (16'h0000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .br_valid      (br_valid),
        .br_cond       (br_cond),
        .zero          (zero),
        .neg           (neg),
        .offset        (offset),
        .jump          (jump),
        .call          (call),
        .ret           (ret),
        .jump_target   (jump_target),
        .pc            (pc),
        .redirected    (redirected),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        br_valid;
        logic [1:0]  cond;
        logic        zero;
        logic        neg;
        logic [15:0] offset;
        logic        jump;
        logic        call;
        logic        ret;
        logic [15:0] tgt;
    } in_t;

    typedef struct {
        in_t         i;
        logic [15:0] pc;
        logic        redir;
        logic        ovf;
        logic        unf;
    } vec_t;

    function automatic in_t nop();
        in_t r;
        r.rst = 0; r.stall = 0; r.br_valid = 0; r.cond = 2'd0; r.zero = 0; r.neg = 0;
        r.offset = 16'h0; r.jump = 0; r.call = 0; r.ret = 0; r.tgt = 16'h0;
        return r;
    endfunction

    function automatic in_t f_rst();
        in_t r = nop(); r.rst = 1; return r;
    endfunction
    function automatic in_t f_jump(input logic [15:0] t);
        in_t r = nop(); r.jump = 1; r.tgt = t; return r;
    endfunction
    function automatic in_t f_call(input logic [15:0] t);
        in_t r = nop(); r.call = 1; r.tgt = t; return r;
    endfunction
    function automatic in_t f_ret();
        in_t r = nop(); r.ret = 1; return r;
    endfunction
    function automatic in_t f_br(input logic [1:0] c, input logic z, input logic n, input logic [15:0] off);
        in_t r = nop(); r.br_valid = 1; r.cond = c; r.zero = z; r.neg = n; r.offset = off; return r;
    endfunction

    function automatic vec_t mkv(input in_t i, input logic [15:0] p, input logic rd, input logic o, input logic u);
        vec_t v; v.i = i; v.pc = p; v.redir = rd; v.ovf = o; v.unf = u; return v;
    endfunction

    task automatic drive(input in_t i);
        reset = i.rst; stall = i.stall; br_valid = i.br_valid; br_cond = i.cond;
        zero = i.zero; neg = i.neg; offset = i.offset; jump = i.jump;
        call = i.call; ret = i.ret; jump_target = i.tgt;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input in_t i);
        drive(i);
        @(posedge clk);
        #1;
    endtask

    task automatic step_chk(input string tag, input in_t i, input logic [15:0] p,
                            input logic rd, input logic o, input logic u);
        step(i);
        chk({tag, " pc"}, pc, p);
        chk({tag, " redirected"}, 16'(redirected), 16'(rd));
        chk({tag, " ras_overflow"}, 16'(ras_overflow), 16'(o));
        chk({tag, " ras_underflow"}, 16'(ras_underflow), 16'(u));
    endtask

    // Reference model: PC plus a bounded list of return addresses, newest at the back.
    logic [15:0] m_pc;
    logic [15:0] m_ras[$];
    logic        m_redir, m_ovf, m_unf;

    task automatic model(input in_t i);
        logic taken;
        m_redir = 0; m_ovf = 0; m_unf = 0;
        case (i.cond)
            2'd0: taken = i.zero;
            2'd1: taken = !i.zero;
            2'd2: taken = i.neg;
            default: taken = !i.neg;
        endcase
        taken = taken && i.br_valid;
        if (i.rst) begin
            m_pc = 16'h0000;
            m_ras.delete();
        end else if (i.stall) begin
            m_pc = m_pc;
        end else if (i.ret) begin
            m_redir = 1;
            if (m_ras.size() > 0) m_pc = m_ras.pop_back();
            else begin m_pc = m_pc + 16'd2; m_unf = 1; end
        end else if (i.call) begin
            m_redir = 1;
            if (m_ras.size() == 4) begin void'(m_ras.pop_front()); m_ovf = 1; end
            m_ras.push_back(m_pc + 16'd2);
            m_pc = i.tgt;
        end else if (i.jump) begin
            m_redir = 1;
            m_pc = i.tgt;
        end else if (taken) begin
            m_redir = 1;
            m_pc = m_pc + i.offset;
        end else begin
            m_pc = m_pc + 16'd2;
        end
    endtask

    vec_t tbl[$];

    initial begin
        in_t stj;
        in_t cr;
        in_t cj;
        in_t rb;
        in_t ri;

        stj = f_jump(16'h7777); stj.stall = 1;
        cr  = f_call(16'h1234); cr.rst = 1;
        cj  = f_call(16'h0300); cj.jump = 1; cj.tgt = 16'h0300;
        rb  = f_br(2'd0, 1'b1, 1'b0, 16'h0040); rb.ret = 1;

        tbl.push_back(mkv(f_rst(),                       16'h0000, 0, 0, 0));
        tbl.push_back(mkv(nop(),                         16'h0002, 0, 0, 0));
        tbl.push_back(mkv(nop(),                         16'h0004, 0, 0, 0));
        tbl.push_back(mkv(nop(),                         16'h0006, 0, 0, 0));
        tbl.push_back(mkv(nop(),                         16'h0008, 0, 0, 0));
        tbl.push_back(mkv(f_jump(16'h0010),              16'h0010, 1, 0, 0));
        tbl.push_back(mkv(f_br(2'd1, 0, 0, 16'hFFF8),    16'h0008, 1, 0, 0));
        tbl.push_back(mkv(f_jump(16'h0010),              16'h0010, 1, 0, 0));
        tbl.push_back(mkv(f_br(2'd1, 1, 0, 16'hFFF8),    16'h0012, 0, 0, 0));
        tbl.push_back(mkv(f_jump(16'h0020),              16'h0020, 1, 0, 0));
        tbl.push_back(mkv(f_br(2'd2, 0, 1, 16'h0004),    16'h0024, 1, 0, 0));
        tbl.push_back(mkv(f_jump(16'h0020),              16'h0020, 1, 0, 0));
        tbl.push_back(mkv(f_br(2'd3, 0, 1, 16'h0004),    16'h0022, 0, 0, 0));
        tbl.push_back(mkv(f_jump(16'h0100),              16'h0100, 1, 0, 0));
        tbl.push_back(mkv(f_call(16'h0400),              16'h0400, 1, 0, 0));
        tbl.push_back(mkv(nop(),                         16'h0402, 0, 0, 0));
        tbl.push_back(mkv(nop(),                         16'h0404, 0, 0, 0));
        tbl.push_back(mkv(f_ret(),                       16'h0102, 1, 0, 0));
        tbl.push_back(mkv(f_call(16'h1000),              16'h1000, 1, 0, 0));
        tbl.push_back(mkv(f_call(16'h2000),              16'h2000, 1, 0, 0));
        tbl.push_back(mkv(f_call(16'h3000),              16'h3000, 1, 0, 0));
        tbl.push_back(mkv(f_call(16'h4000),              16'h4000, 1, 0, 0));
        tbl.push_back(mkv(f_call(16'h5000),              16'h5000, 1, 1, 0));
        tbl.push_back(mkv(f_ret(),                       16'h4002, 1, 0, 0));
        tbl.push_back(mkv(f_ret(),                       16'h3002, 1, 0, 0));
        tbl.push_back(mkv(f_ret(),                       16'h2002, 1, 0, 0));
        tbl.push_back(mkv(f_ret(),                       16'h1002, 1, 0, 0));
        tbl.push_back(mkv(f_ret(),                       16'h1004, 1, 0, 1));
        tbl.push_back(mkv(nop(),                         16'h1006, 0, 0, 0));
        tbl.push_back(mkv(stj,                           16'h1006, 0, 0, 0));
        tbl.push_back(mkv(stj,                           16'h1006, 0, 0, 0));
        tbl.push_back(mkv(stj,                           16'h1006, 0, 0, 0));
        tbl.push_back(mkv(f_jump(16'hFFFE),              16'hFFFE, 1, 0, 0));
        tbl.push_back(mkv(cr,                            16'h0000, 0, 0, 0));
        tbl.push_back(mkv(f_ret(),                       16'h0002, 1, 0, 1));
        tbl.push_back(mkv(f_jump(16'hFFFE),              16'hFFFE, 1, 0, 0));
        tbl.push_back(mkv(nop(),                         16'h0000, 0, 0, 0));
        tbl.push_back(mkv(cj,                            16'h0300, 1, 0, 0));
        tbl.push_back(mkv(rb,                            16'h0002, 1, 0, 0));

        drive(nop());
        foreach (tbl[k]) begin
            step_chk($sformatf("vec%0d", k), tbl[k].i, tbl[k].pc, tbl[k].redir, tbl[k].ovf, tbl[k].unf);
        end

        // Reset while the stack is full and a call is pending: no overflow, stack cleared.
        step_chk("seqA rst",   f_rst(),           16'h0000, 0, 0, 0);
        step_chk("seqA c1",    f_call(16'h0010),  16'h0010, 1, 0, 0);
        step_chk("seqA c2",    f_call(16'h0020),  16'h0020, 1, 0, 0);
        step_chk("seqA c3",    f_call(16'h0030),  16'h0030, 1, 0, 0);
        step_chk("seqA c4",    f_call(16'h0040),  16'h0040, 1, 0, 0);
        step_chk("seqA crst",  cr,                16'h0000, 0, 0, 0);
        step_chk("seqA ret",   f_ret(),           16'h0002, 1, 0, 1);
        // Call immediately followed by ret returns to call PC + 2.
        step_chk("seqB call",  f_call(16'h0080),  16'h0080, 1, 0, 0);
        step_chk("seqB ret",   f_ret(),           16'h0004, 1, 0, 0);

        // Randomised stimulus against the reference model.
        step(f_rst());
        model(f_rst());
        for (int n = 0; n < 1500; n++) begin
            ri = nop();
            ri.rst      = ($urandom_range(0, 99) == 0);
            ri.stall    = ($urandom_range(0, 7) == 0);
            ri.ret      = ($urandom_range(0, 4) == 0);
            ri.call     = ($urandom_range(0, 3) == 0);
            ri.jump     = ($urandom_range(0, 6) == 0);
            ri.br_valid = ($urandom_range(0, 2) == 0);
            ri.cond     = 2'($urandom_range(0, 3));
            ri.zero     = 1'($urandom);
            ri.neg      = 1'($urandom);
            ri.offset   = 16'($urandom);
            ri.tgt      = 16'($urandom);
            step(ri);
            model(ri);
            chk($sformatf("rnd%0d pc", n), pc, m_pc);
            chk($sformatf("rnd%0d redirected", n), 16'(redirected), 16'(m_redir));
            chk($sformatf("rnd%0d ras_overflow", n), 16'(ras_overflow), 16'(m_ovf));
            chk($sformatf("rnd%0d ras_underflow", n), 16'(ras_underflow), 16'(m_unf));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
